// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
// Holds the FSM encoding and the round-robin pick function.
package axis_arb_pkg;

  localparam int MAX_PORTS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // First valid index scanning upward from ptr+1, wrapping at n.
  function automatic logic [3:0] rr_pick(
    input logic [15:0] valid,
    input logic [3:0]  ptr,
    input logic [4:0]  n
  );
    logic [3:0] pick;
    logic [4:0] idx;
    pick = ptr;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= n) idx = idx - n;
      if (5'(k) <= n && valid[idx[3:0]])
        pick = idx[3:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry fully registered AXI-Stream buffer.
// Input ready is a flop; a stalled output parks one beat in the skid slot.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             s_fire;

  assign s_fire = s_valid && s_ready;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!skid_valid) begin
      if (s_fire && m_valid && !m_ready) begin
        skid_data  <= s_data;
        skid_valid <= 1'b1;
        s_ready    <= 1'b0;
      end else begin
        s_ready <= 1'b1;
        if (!m_valid || m_ready) begin
          m_valid <= s_fire;
          m_data  <= s_data;
        end
      end
    end else if (m_ready) begin
      m_data     <= skid_data;
      m_valid    <= 1'b1;
      skid_valid <= 1'b0;
      s_ready    <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter: N AXI-Stream slaves onto one master.
// A grant is held from first beat until the tlast beat is accepted.
module axis_rr_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int DATA_W  = 32,
  localparam int ID_W    = $clog2(N_PORTS)
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic [N_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]        s_axis_tvalid,
  output logic [N_PORTS-1:0]        s_axis_tready,
  input  logic [N_PORTS-1:0]        s_axis_tlast,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  output logic                      grant_busy
);

  localparam int BW = ID_W + 1 + DATA_W;

  arb_state_t      state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] ptr;
  logic [3:0]      pick;
  logic [BW-1:0]   buf_in;
  logic [BW-1:0]   buf_out;
  logic            buf_valid;
  logic            buf_ready;
  logic            accept;
  logic            locked;

  assign locked    = (state == ST_LOCK);
  assign pick      = rr_pick(16'(s_axis_tvalid), 4'(ptr),
                             5'(N_PORTS));
  assign buf_valid = locked && s_axis_tvalid[grant];
  assign accept    = buf_valid && buf_ready;
  assign buf_in    = {grant, s_axis_tlast[grant],
                      s_axis_tdata[grant*DATA_W +: DATA_W]};

  always_comb begin
    s_axis_tready = '0;
    if (locked) s_axis_tready[grant] = buf_ready;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= ID_W'(N_PORTS - 1);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            grant <= ID_W'(pick);
            state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept && s_axis_tlast[grant]) begin
            state <= ST_IDLE;
            ptr   <= grant;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH(BW)
  ) u_skid (
    .axis_aclk   (axis_aclk),
    .axis_aresetn(axis_aresetn),
    .s_data      (buf_in),
    .s_valid     (buf_valid),
    .s_ready     (buf_ready),
    .m_data      (buf_out),
    .m_valid     (m_axis_tvalid),
    .m_ready     (m_axis_tready)
  );

  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = buf_out;
  assign grant_busy = locked;

endmodule
